// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler
//   Time-multiplexed scan controller for a 4-digit, active-low 7-segment
//   display. It normally shows a 4-digit BCD score. A one-shot message of raw
//   segment bytes can pre-empt the score for MSG_FRAMES full frames.
//
//   Handshake on msg_req/msg_ack:
//     msg_req is level-sampled. It is accepted only in SCORE, and not in the
//     cycle where msg_done is high. On acceptance, msg_segments is captured and
//     msg_ack pulses for one cycle on the following cycle, together with the
//     rise of msg_busy. There is no back-pressure beyond msg_busy: requests
//     made while busy are dropped.
//
// Ports:
//   clock         system clock
//   reset         asynchronous, active-high reset
//   score_digits  BCD score, nibble k = digit k (digit 0 = rightmost)
//   msg_req       request to show msg_segments
//   msg_segments  raw active-low patterns, byte k = digit k
//   msg_ack       one-cycle pulse, request accepted
//   msg_busy      high while a message is pending or displayed
//   msg_done      one-cycle pulse when the message display ends
//   segment       active-low {dp,g,f,e,d,c,b,a}
//   an_val        active-low one-hot anode select
module seg_scan_scheduler #(
  parameter int SCAN_DIV   = 100000,
  parameter int MSG_FRAMES = 250,
  parameter bit LZB        = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] score_digits,
  input  logic        msg_req,
  input  logic [31:0] msg_segments,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic        msg_done,
  output logic [7:0]  segment,
  output logic [3:0]  an_val
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (MSG_FRAMES > 1) ? $clog2(MSG_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(MSG_FRAMES - 1);

  typedef enum logic [1:0] {
    SCORE    = 2'd0,
    MSG_WAIT = 2'd1,
    MSG_SHOW = 2'd2
  } state_t;

  state_t        state_q, state_nxt;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q, idx_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [31:0]   msg_q;
  logic          ack_q, done_q, done_nxt;
  logic [7:0]    seg_q, seg_nxt;
  logic [3:0]    an_q, an_nxt;

  logic          tick, boundary, capture;
  logic [3:0]    score_nib;
  logic          score_blank;
  logic [7:0]    msg_byte;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;  // non-BCD nibble shows a dash
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    idx_nxt  = idx_q + 2'd1;
    boundary = tick && (idx_nxt == 2'd0);
    // The cycle msg_done is high is the first cycle back in SCORE; a request
    // there is dropped so a held request cannot chain straight onto the end.
    capture  = (state_q == SCORE) && msg_req && !done_q;

    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    done_nxt  = 1'b0;

    case (state_q)
      SCORE: begin
        if (capture) state_nxt = MSG_WAIT;
      end
      MSG_WAIT: begin
        if (boundary) begin
          state_nxt = MSG_SHOW;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MSG_SHOW: begin
        if (boundary) begin
          if (cnt_q == '0) begin
            state_nxt = SCORE;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_q - CW'(1);
          end
        end
      end
      default: state_nxt = SCORE;
    endcase

    // Content for the digit about to be shown, chosen by the state the tick
    // lands in, so the first and last message ticks line up with boundaries.
    score_nib   = score_digits[{idx_nxt, 2'b00} +: 4];
    score_blank = LZB && (idx_nxt != 2'd0) &&
                  ((score_digits >> {idx_nxt, 2'b00}) == 16'h0000);
    msg_byte    = msg_q[{idx_nxt, 3'b000} +: 8];

    if (state_nxt == MSG_SHOW) seg_nxt = msg_byte;
    else if (score_blank)      seg_nxt = 8'hFF;
    else                       seg_nxt = bcd_to_seg(score_nib);

    an_nxt = ~(4'b0001 << idx_nxt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= SCORE;
    else       state_q <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= 2'd3;
      cnt_q   <= '0;
      msg_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= 8'hFF;
      an_q    <= 4'hF;
    end else begin
      ack_q  <= capture;
      done_q <= done_nxt;
      cnt_q  <= cnt_nxt;
      if (capture) msg_q <= msg_segments;
      if (tick) begin
        presc_q <= '0;
        idx_q   <= idx_nxt;
        seg_q   <= seg_nxt;
        an_q    <= an_nxt;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign msg_ack  = ack_q;
  assign msg_done = done_q;
  assign msg_busy = (state_q != SCORE);
  assign segment  = seg_q;
  assign an_val   = an_q;

endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
Time-multiplexed scan controller for the 4-digit 7-segment display. It owns the segment/anode drivers and shares the display between two sources: the continuous score/level readout (4 BCD digits) and a one-shot message source (raw segment patterns) that briefly pre-empts it. The block sits between the game logic and the board display pins.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (one scan tick every SCAN_DIV cycles, legal ≥ 2).
MSG_FRAMES, 250, full 4-digit frames a message is held on display (legal ≥ 1).
LZB, 1, 1 = blank leading zeros of the BCD score, 0 = show all digits.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
score_digits  in  16  BCD score, nibble k = digit k (digit 0 = rightmost)
msg_req  in  1  request to show msg_segments (level-sampled each cycle)
msg_segments  in  32  raw active-low patterns, byte k = digit k
msg_ack  out  1  one-cycle pulse, request accepted
msg_busy  out  1  high while a message is pending or displayed
msg_done  out  1  one-cycle pulse when the message display ends
segment  out  8  active-low {dp,g,f,e,d,c,b,a}
an_val  out  4  active-low one-hot anode select

Behaviour:
- Reset (async): segment=8'hFF, an_val=4'hF, msg_ack=0, msg_busy=0, msg_done=0, state=SCORE, prescaler=0, digit index=3, frame count=0, captured message cleared.
- Prescaler counts 0..SCAN_DIV-1. The scan tick is the cycle when it equals SCAN_DIV-1, and it then wraps to 0.
- On each tick: idx <= idx+1 mod 4. an_val and segment are updated in the same registered update for the new idx. Digit 0 is shown on the first tick after reset.
- Anode map: idx0=4'b1110, idx1=4'b1101, idx2=4'b1011, idx3=4'b0111.
- A frame boundary is a tick whose new idx is 0.
- BCD decode: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A–F=BF (dash).
- Leading-zero blanking (LZB=1): digit k (k=3..1) outputs FF if its nibble and all higher nibbles are 0. Digit 0 is never blanked.
- score_digits is sampled on the tick that displays the digit. There is no frame-level snapshot.
- States:
  - SCORE: display score. If msg_req=1, capture msg_segments, pulse msg_ack next cycle, set msg_busy=1, go to MSG_WAIT.
  - MSG_WAIT: keep showing score. At the next frame boundary, go to MSG_SHOW, load count=MSG_FRAMES-1, and display message byte 0 on that tick.
  - MSG_SHOW: display captured bytes verbatim; no decode or blanking. At each frame boundary: if count==0, go to SCORE, display score digit 0 on that tick, pulse msg_done, clear msg_busy in the same cycle. Otherwise count-1.
- Message shown for exactly MSG_FRAMES×4 ticks.
- msg_req while msg_busy=1 is ignored (no ack, no recapture).
- msg_req in the same cycle that msg_done pulses is ignored. It is accepted on a later cycle if still held.
- Capture and tick in the same cycle: capture completes and the state becomes MSG_WAIT. The tick itself follows SCORE rules. If that tick is a frame boundary, it does not start the message; the message starts at the following boundary.
- Reset mid-message: message is abandoned with no msg_done, and display returns to score.
- msg_ack, msg_done: single-cycle, never both high together.

Test Plan:
1. Reset asserted mid-count, SCAN_DIV=4 → segment=FF, an_val=F immediately. First tick 4 cycles after release shows an_val=1110.
2. score_digits=16'h0107, LZB=1 → per frame: idx0 F8 (7), idx1 C0 (0, not leading), idx2 F9 (1), idx3 FF. Anodes cycle 1110→1101→1011→0111→1110.
3. score_digits=16'h000A, LZB=0 → idx0 BF, idx1..3 C0.
4. MSG_FRAMES=2, msg_req one cycle with msg_segments=32'h86AF_C0C7 in SCORE at idx1 → msg_ack next cycle, msg_busy=1. Score continues until next frame boundary. Then 8 ticks of C7, C0, AF, 86 repeated. msg_done pulses on the following boundary, score digit 0 shown.
5. Second msg_req during MSG_WAIT/MSG_SHOW with different data → no msg_ack, original pattern displayed unchanged.
6. Reset pulse during MSG_SHOW → msg_busy=0 with no msg_done. Score display resumes from digit 0 after first tick.
